led_pwm_lbus: RTL

//  Multi-channel LED controller slave on the XT local bus (lb_slave_t, MatchWLB/MatchRLB decode).
//  Per channel: static on/off, PWM dimming, blink, or blink-gated PWM.

---
 rtl/led_pwm_lbus.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/led_pwm_lbus.sv
// Multi-channel LED controller on the XT local bus: static, PWM, blink and blink-gated PWM
// per channel, sharing one prescaler / PWM counter / blink timebase.
module led_pwm_lbus #(
    parameter int         LED_NUM    = 8,
    parameter int         PWM_BITS   = 8,
    parameter int         PRESCALE_W = 16,
    parameter logic [7:0] BASE_ADDR  = 8'd20,
    parameter bit         ACTIVE_LOW = 1'b1
) (
    input  logic                 lb_clk,
    input  logic                 rst_n,
    input  logic [7:0]           xt_lb_addr,
    input  logic [31:0]          xt_lb_wdata,
    input  logic                 xt_lb_wr,
    input  logic                 xt_lb_rd,
    output logic [31:0]          rdata,
    output logic [LED_NUM-1:0]   led
);

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'd0,
        MODE_PWM       = 2'd1,
        MODE_BLINK     = 2'd2,
        MODE_BLINK_PWM = 2'd3
    } led_mode_e;

    logic [LED_NUM-1:0]    r_on;
    logic [2*LED_NUM-1:0]  r_mode;
    logic [PRESCALE_W-1:0] r_presc;
    logic [7:0]            r_blink;
    logic [PWM_BITS-1:0]   r_duty        [LED_NUM];
    logic [PWM_BITS-1:0]   r_duty_active [LED_NUM];

    logic [PRESCALE_W-1:0] r_presc_cnt;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [7:0]            r_blink_cnt;
    logic                  r_blink_phase;
    logic [LED_NUM-1:0]    r_led;

    logic                  w_wr_on;
    logic                  w_wr_mode;
    logic                  w_wr_presc;
    logic                  w_wr_blink;
    logic [LED_NUM-1:0]    w_wr_duty;
    logic                  w_tick;
    logic                  w_wrap;
    logic [LED_NUM-1:0]    w_pwm_on;
    logic [LED_NUM-1:0]    w_lit;
    logic                  w_unused_wdata;

    assign w_unused_wdata = &{1'b0, xt_lb_wdata};

    always_comb begin
        w_wr_on    = xt_lb_wr && (xt_lb_addr == BASE_ADDR);
        w_wr_mode  = xt_lb_wr && (xt_lb_addr == BASE_ADDR + 8'd1);
        w_wr_presc = xt_lb_wr && (xt_lb_addr == BASE_ADDR + 8'd2);
        w_wr_blink = xt_lb_wr && (xt_lb_addr == BASE_ADDR + 8'd3);
        w_wr_duty  = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            if (xt_lb_wr && (xt_lb_addr == BASE_ADDR + 8'(4 + i))) begin
                w_wr_duty[i] = 1'b1;
            end
        end
    end

    // A PRESC write restarts the prescaler and suppresses any tick due in that cycle.
    assign w_tick = (r_presc_cnt == r_presc) && !w_wr_presc;
    assign w_wrap = w_tick && (&r_pwm_cnt);

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on    <= '0;
            r_mode  <= '0;
            r_presc <= '0;
            r_blink <= '0;
            for (int i = 0; i < LED_NUM; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            if (w_wr_on) begin
                r_on <= xt_lb_wdata[LED_NUM-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= xt_lb_wdata[2*LED_NUM-1:0];
            end
            if (w_wr_presc) begin
                r_presc <= xt_lb_wdata[PRESCALE_W-1:0];
            end
            if (w_wr_blink) begin
                r_blink <= xt_lb_wdata[7:0];
            end
            for (int i = 0; i < LED_NUM; i++) begin
                if (w_wr_duty[i]) begin
                    r_duty[i] <= xt_lb_wdata[PWM_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt   <= '0;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_wr_presc || (r_presc_cnt == r_presc)) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + 1'b1;
            end
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            // Exact-match compare: a lowered BLINK lets the count roll past 255 first.
            if (w_wrap) begin
                if (r_blink_cnt == r_blink) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    // Duty shadow: reloaded only at the period boundary so a period never glitches.
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LED_NUM; i++) begin
                r_duty_active[i] <= '0;
            end
        end else if (w_wrap) begin
            for (int i = 0; i < LED_NUM; i++) begin
                r_duty_active[i] <= w_wr_duty[i] ? xt_lb_wdata[PWM_BITS-1:0] : r_duty[i];
            end
        end
    end

    always_comb begin
        w_pwm_on = '0;
        w_lit    = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            w_pwm_on[i] = (r_pwm_cnt < r_duty_active[i]);
            case (led_mode_e'(r_mode[2*i +: 2]))
                MODE_STATIC:    w_lit[i] = r_on[i];
                MODE_PWM:       w_lit[i] = r_on[i] & w_pwm_on[i];
                MODE_BLINK:     w_lit[i] = r_on[i] & r_blink_phase;
                MODE_BLINK_PWM: w_lit[i] = r_on[i] & r_blink_phase & w_pwm_on[i];
                default:        w_lit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= {LED_NUM{ACTIVE_LOW}};
        end else begin
            r_led <= w_lit ^ {LED_NUM{ACTIVE_LOW}};
        end
    end

    assign led = r_led;

    always_comb begin
        rdata = 32'h0;
        if (xt_lb_rd) begin
            if (xt_lb_addr == BASE_ADDR) begin
                rdata = 32'(r_on);
            end else if (xt_lb_addr == BASE_ADDR + 8'd1) begin
                rdata = 32'(r_mode);
            end else if (xt_lb_addr == BASE_ADDR + 8'd2) begin
                rdata = 32'(r_presc);
            end else if (xt_lb_addr == BASE_ADDR + 8'd3) begin
                rdata = 32'(r_blink);
            end
            for (int i = 0; i < LED_NUM; i++) begin
                if (xt_lb_addr == BASE_ADDR + 8'(4 + i)) begin
                    rdata = 32'(r_duty[i]);
                end
            end
        end
    end

endmodule
